// File: rtl/qm_tx_pkg.sv
// Shared definitions for the queue-manager transmit sequencer.
package qm_tx_pkg;

  localparam int LEN_W       = 12;
  localparam int IFG_DEF     = 12;
  localparam int MAX_LEN_DEF = 1518;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_XMIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/qm_tx.sv
// Pulls frame descriptors and bytes from the queue-manager FIFOs and streams
// frames to the egress MAC, discarding empty and oversize frames.
//
// state | meaning
// IDLE  | wait for a queued pointer while the MAC is ready; read it
// LEN   | pointer data valid; classify length
// XMIT  | read len bytes, each forwarded one cycle later
// DRAIN | read and discard len bytes of an oversize frame
// GAP   | inter-frame gap (first cycle overlaps the last forwarded byte)
module qm_tx
  import qm_tx_pkg::*;
#(
  parameter int IFG     = IFG_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ptr_fifo_empty,
  output logic        ptr_fifo_rd,
  input  logic [15:0] ptr_fifo_dout,
  output logic        data_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  input  logic        tx_rdy,
  output logic        tx_dv,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic [7:0]  tx_data,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   rd_cnt_q;
  logic [15:0]        gap_q;
  logic               tx_dv_q, tx_sof_q, tx_eof_q;
  logic [15:0]        frame_cnt_q, drop_cnt_q;

  logic [LEN_W-1:0]   len_in;
  logic               len_zero, len_big, last_rd, start_ok;
  logic               unused_ptr_hi;

  assign len_in        = ptr_fifo_dout[LEN_W-1:0];
  assign unused_ptr_hi = ^ptr_fifo_dout[15:LEN_W];
  assign len_zero      = (len_in == '0);
  assign len_big       = (int'({20'd0, len_in}) > MAX_LEN);
  assign last_rd       = (rd_cnt_q == len_q - LEN_W'(1));
  assign start_ok      = !ptr_fifo_empty && tx_rdy;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_LEN;
      ST_LEN: begin
        if (len_zero)     state_d = ST_GAP;
        else if (len_big) state_d = ST_DRAIN;
        else              state_d = ST_XMIT;
      end
      ST_XMIT,
      ST_DRAIN: if (last_rd) state_d = ST_GAP;
      ST_GAP:   if (gap_q == 16'd0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read strobes are gated by rst so nothing is pulled from the FIFOs while they clear.
  always_comb begin
    ptr_fifo_rd  = 1'b0;
    data_fifo_rd = 1'b0;
    if (!rst) begin
      ptr_fifo_rd  = (state_q == ST_IDLE) && start_ok;
      data_fifo_rd = (state_q == ST_XMIT) || (state_q == ST_DRAIN);
    end
    tx_dv     = tx_dv_q;
    tx_sof    = tx_sof_q;
    tx_eof    = tx_eof_q;
    tx_data   = tx_dv_q ? data_fifo_dout : 8'h00;
    frame_cnt = frame_cnt_q;
    drop_cnt  = drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      rd_cnt_q    <= '0;
      gap_q       <= 16'd0;
      tx_dv_q     <= 1'b0;
      tx_sof_q    <= 1'b0;
      tx_eof_q    <= 1'b0;
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      tx_dv_q  <= (state_q == ST_XMIT);
      tx_sof_q <= (state_q == ST_XMIT) && (rd_cnt_q == '0);
      tx_eof_q <= (state_q == ST_XMIT) && last_rd;
      case (state_q)
        ST_LEN: begin
          len_q    <= len_in;
          rd_cnt_q <= '0;
          if (len_zero || len_big) drop_cnt_q <= sat_inc16(drop_cnt_q);
          if (len_zero) gap_q <= 16'(IFG);
        end
        ST_XMIT: begin
          rd_cnt_q <= rd_cnt_q + LEN_W'(1);
          if (last_rd) begin
            gap_q       <= 16'(IFG);
            frame_cnt_q <= sat_inc16(frame_cnt_q);
          end
        end
        ST_DRAIN: begin
          rd_cnt_q <= rd_cnt_q + LEN_W'(1);
          if (last_rd) gap_q <= 16'(IFG);
        end
        ST_GAP: if (gap_q != 16'd0) gap_q <= gap_q - 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/qm_tx.md
QM_TX -- requirements
Module: qm_tx

Interface
REQ-001 Parameter IFG, default 12, idle cycles enforced between the last byte of one frame and the next pointer read.
REQ-002 Parameter MAX_LEN, default 1518, largest frame length in bytes that is transmitted; longer frames are discarded.
REQ-003 Port clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port ptr_fifo_empty  input  1  queue-manager pointer FIFO empty flag.
REQ-006 Port ptr_fifo_rd  output  1  pointer FIFO read strobe.
REQ-007 Port ptr_fifo_dout  input  16  frame descriptor; bits [11:0] = byte length, bits [15:12] ignored.
REQ-008 Port data_fifo_rd  output  1  data FIFO read strobe, one byte per asserted cycle.
REQ-009 Port data_fifo_dout  input  8  frame byte.
REQ-010 Port tx_rdy  input  1  egress MAC can accept a new frame.
REQ-011 Port tx_dv  output  1  tx_data valid.
REQ-012 Port tx_sof  output  1  first byte of frame, coincident with tx_dv.
REQ-013 Port tx_eof  output  1  last byte of frame, coincident with tx_dv.
REQ-014 Port tx_data  output  8  frame byte to the MAC.
REQ-015 Port frame_cnt  output  16  frames transmitted; saturates at 16'hFFFF.
REQ-016 Port drop_cnt  output  16  frames discarded; saturates at 16'hFFFF.

Function
REQ-017 Both FIFOs have a 1-cycle read latency: dout is valid in the cycle after the rd strobe.
REQ-018 State machine: IDLE, LEN, XMIT, DRAIN, GAP.
REQ-019 IDLE: when ptr_fifo_empty=0 and tx_rdy=1 in cycle T, ptr_fifo_rd=1 for exactly cycle T and the state moves to LEN; otherwise it stays in IDLE.
REQ-020 LEN (cycle T+1): capture len=ptr_fifo_dout[11:0]. len=0 goes to GAP and increments drop_cnt. len>MAX_LEN goes to DRAIN. Otherwise it goes to XMIT.
REQ-021 XMIT: data_fifo_rd=1 for exactly len consecutive cycles, starting T+2; a 12-bit read counter is compared against len.
REQ-022 Byte output: tx_dv=1, tx_data=data_fifo_dout in the cycle after each data_fifo_rd, giving len contiguous cycles T+3..T+2+len.
REQ-023 Markers: tx_sof on the first tx_dv cycle, tx_eof on the last; a frame with len=1 asserts both in the same cycle.
REQ-024 tx_rdy is sampled only in IDLE; a frame is never stalled or truncated once started.
REQ-025 DRAIN: data_fifo_rd=1 for len cycles with tx_dv/tx_sof/tx_eof held 0, keeping the data FIFO aligned with the pointer FIFO; drop_cnt increments once.
REQ-026 frame_cnt increments once per frame, in the tx_eof cycle.
REQ-027 GAP: entered after the last tx_dv (or last drain byte, or from LEN when len=0); hold for IFG cycles, then return to IDLE. The earliest next ptr_fifo_rd is cycle T+3+len+IFG.
REQ-028 ptr_fifo_rd and data_fifo_rd are never asserted in the same cycle; ptr_fifo_rd is never asserted while ptr_fifo_empty=1.
REQ-029 When not driving a byte, tx_data=0.

Reset
REQ-030 While rst=1 at a clock edge: state=IDLE, all counters=0, and all outputs (ptr_fifo_rd, data_fifo_rd, tx_dv, tx_sof, tx_eof, tx_data, frame_cnt, drop_cnt) are 0.
REQ-031 rst mid-frame aborts immediately with no tx_eof; the upstream FIFOs are cleared by the same rst.

Structure
REQ-032 Package qm_tx_pkg holds the state encodings, LEN_W=12, and the IFG/MAX_LEN defaults.
REQ-033 Single module with no sub-module; the FIFOs belong to the upstream queue manager.

Verification
REQ-034 Pointer 0x003C with 60 bytes 0x00..0x3B and tx_rdy=1 -> ptr_fifo_rd at T, tx_sof with 0x00 at T+3, tx_eof with 0x3B at T+62, frame_cnt=1.
REQ-035 Two queued 64-byte frames, IFG=12 -> second ptr_fifo_rd exactly 79 cycles after the first, and no gap inside either frame.
REQ-036 Pointer 0x0600 (1536 > MAX_LEN) followed by a 64-byte frame -> 1536 data reads with tx_dv=0, drop_cnt=1, then the 64-byte frame is output correctly.
REQ-037 Pointer length 1, then pointer length 0 -> one tx_dv cycle with tx_sof=tx_eof=1; the zero-length pointer causes no data reads and drop_cnt=1.
REQ-038 tx_rdy=0 with pointer FIFO non-empty -> no reads; tx_rdy rises, next cycle still samples -> ptr_fifo_rd in the cycle tx_rdy=1 is seen.
REQ-039 rst=1 at byte 20 of a 100-byte frame -> all outputs 0 on the next edge, no tx_eof, state IDLE.
